// File: rtl/huff_code_sched.sv
// Sequencer for the Huffman code-generation pipeline: sort -> length -> canonical codes -> alphabet sort -> serialize.
// Canonical codewords are produced here, one symbol per cycle; each waiting stage is guarded by a watchdog.
module huff_code_sched #(
    parameter int TOTAL_SYMBOLS = 10,
    parameter int ADDR_WIDTH    = 4,
    parameter int MAXHIGHT      = 10,
    parameter int TIMEOUT       = 1023,
    parameter int WD_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  sort_start,
    input  logic                  sort_done,
    output logic                  len_start,
    input  logic                  len_done,
    output logic [ADDR_WIDTH-1:0] len_idx,
    input  logic [MAXHIGHT-1:0]   len_in,
    output logic                  code_we,
    output logic [ADDR_WIDTH-1:0] code_idx,
    output logic [MAXHIGHT-1:0]   code_out,
    output logic                  alpha_start,
    input  logic                  alpha_done,
    output logic                  ser_start,
    input  logic                  ser_done,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            err_code,
    output logic [2:0]            err_stage
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SORT  = 3'd1,
        S_LEN   = 3'd2,
        S_CODE  = 3'd3,
        S_ALPHA = 3'd4,
        S_SER   = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    localparam int CW = MAXHIGHT + 1;
    localparam logic [MAXHIGHT-1:0]   MAX_LEN  = MAXHIGHT'(MAXHIGHT);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TOTAL_SYMBOLS - 1);
    localparam logic [WD_WIDTH-1:0]   WD_LIMIT = WD_WIDTH'(TIMEOUT - 1);

    state_t                state, state_nxt;
    logic                  entry;
    logic [WD_WIDTH-1:0]   wd;
    logic [MAXHIGHT-1:0]   prev_len;
    logic [MAXHIGHT-1:0]   code_prev;

    logic [CW-1:0]         code_calc;
    logic                  len_bad, order_bad, ovf;
    logic [2:0]            code_fcode;
    logic [2:0]            fault_code;
    logic                  fault;
    logic                  counting;
    logic                  stage_done;
    logic                  start_ok;

    // Canonical codeword for the current symbol, computed one bit wider to expose overflow.
    always_comb begin
        code_calc = '0;
        len_bad   = (len_in == '0) || (len_in > MAX_LEN);
        order_bad = (len_idx != '0) && (len_in < prev_len);
        if (len_idx != '0) begin
            code_calc = ({1'b0, code_prev} + CW'(1)) << (len_in - prev_len);
        end
        ovf = code_calc[MAXHIGHT] || ((code_calc >> len_in) != '0);
        code_fcode = 3'd0;
        if (len_bad) begin
            code_fcode = 3'd2;
        end else if (order_bad) begin
            code_fcode = 3'd3;
        end else if (ovf) begin
            code_fcode = 3'd4;
        end
    end

    always_comb begin
        counting   = (state == S_SORT) || (state == S_LEN) ||
                     (state == S_ALPHA) || (state == S_SER);
        stage_done = 1'b0;
        case (state)
            S_SORT:  stage_done = sort_done;
            S_LEN:   stage_done = len_done;
            S_ALPHA: stage_done = alpha_done;
            S_SER:   stage_done = ser_done;
            default: stage_done = 1'b0;
        endcase
        // A done level left over from the previous run must not be taken on entry.
        stage_done = stage_done && !entry;
    end

    always_comb begin
        state_nxt  = state;
        fault      = 1'b0;
        fault_code = 3'd0;
        start_ok   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = S_SORT;
                end
            end
            S_SORT, S_LEN, S_ALPHA, S_SER: begin
                if (wd == WD_LIMIT) begin
                    fault      = 1'b1;
                    fault_code = 3'd1;
                    state_nxt  = S_ERR;
                end else if (stage_done) begin
                    case (state)
                        S_SORT:  state_nxt = S_LEN;
                        S_LEN:   state_nxt = S_CODE;
                        S_ALPHA: state_nxt = S_SER;
                        default: state_nxt = S_DONE;
                    endcase
                end
            end
            S_CODE: begin
                if (code_fcode != 3'd0) begin
                    fault      = 1'b1;
                    fault_code = code_fcode;
                    state_nxt  = S_ERR;
                end else if (len_idx == LAST_IDX) begin
                    state_nxt = S_ALPHA;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt  = S_IDLE;
            fault      = 1'b0;
            fault_code = 3'd0;
            start_ok   = 1'b0;
        end
    end

    always_comb begin
        code_we  = (state == S_CODE) && !abort && (code_fcode == 3'd0);
        code_idx = len_idx;
        code_out = code_we ? code_calc[MAXHIGHT-1:0] : '0;
        busy     = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            entry       <= 1'b0;
            wd          <= '0;
            len_idx     <= '0;
            prev_len    <= '0;
            code_prev   <= '0;
            sort_start  <= 1'b0;
            len_start   <= 1'b0;
            alpha_start <= 1'b0;
            ser_start   <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= 3'd0;
            err_stage   <= 3'd0;
        end else begin
            state       <= state_nxt;
            entry       <= (state_nxt != state);
            sort_start  <= (state_nxt == S_SORT)  && (state != S_SORT);
            len_start   <= (state_nxt == S_LEN)   && (state != S_LEN);
            alpha_start <= (state_nxt == S_ALPHA) && (state != S_ALPHA);
            ser_start   <= (state_nxt == S_SER)   && (state != S_SER);

            if (state_nxt != state || !counting) begin
                wd <= '0;
            end else begin
                wd <= wd + WD_WIDTH'(1);
            end

            if (state == S_CODE && state_nxt == S_CODE) begin
                len_idx <= len_idx + ADDR_WIDTH'(1);
            end else begin
                len_idx <= '0;
            end

            if (code_we) begin
                prev_len  <= len_in;
                code_prev <= code_calc[MAXHIGHT-1:0];
            end

            if (abort || start_ok) begin
                done      <= 1'b0;
                err       <= 1'b0;
                err_code  <= 3'd0;
                err_stage <= 3'd0;
            end else begin
                if (state == S_SER && state_nxt == S_DONE) begin
                    done <= 1'b1;
                end
                if (fault) begin
                    err       <= 1'b1;
                    err_code  <= fault_code;
                    err_stage <= state;
                end
            end
        end
    end

endmodule

// File: tb/tb_huff_code_sched.sv
// Directed bench for huff_code_sched: stage responders, codeword capture and hand-computed expectations.
module tb_huff_code_sched;

    localparam int TOTAL_SYMBOLS = 10;
    localparam int ADDR_WIDTH    = 4;
    localparam int MAXHIGHT      = 10;
    localparam int TIMEOUT       = 1023;
    localparam int WD_WIDTH      = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic                  sort_start, len_start, alpha_start, ser_start;
    logic                  sort_done, len_done, alpha_done, ser_done;
    logic [ADDR_WIDTH-1:0] len_idx, code_idx;
    logic [MAXHIGHT-1:0]   len_in, code_out;
    logic                  code_we, busy, done, err;
    logic [2:0]            err_code, err_stage;

    logic [MAXHIGHT-1:0]   lens [0:15];
    logic [3:0]            dn_r = 4'b0;
    bit                    auto_en [0:3] = '{1, 1, 1, 1};
    bit                    force_alpha = 1'b0;

    int                    wr_cnt;
    logic [MAXHIGHT-1:0]   cap [0:15];
    bit                    wr_seen [0:15];

    int                    n_chk = 0;
    int                    n_fail = 0;

    int                    exp_t1 [0:9] = '{0, 2, 6, 14, 30, 62, 126, 254, 510, 511};

    assign len_in     = lens[len_idx];
    assign sort_done  = dn_r[0];
    assign len_done   = dn_r[1];
    assign alpha_done = dn_r[2] | force_alpha;
    assign ser_done   = dn_r[3];

    always #5 clk = ~clk;

    huff_code_sched #(
        .TOTAL_SYMBOLS(TOTAL_SYMBOLS),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .MAXHIGHT     (MAXHIGHT),
        .TIMEOUT      (TIMEOUT),
        .WD_WIDTH     (WD_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .sort_start (sort_start),
        .sort_done  (sort_done),
        .len_start  (len_start),
        .len_done   (len_done),
        .len_idx    (len_idx),
        .len_in     (len_in),
        .code_we    (code_we),
        .code_idx   (code_idx),
        .code_out   (code_out),
        .alpha_start(alpha_start),
        .alpha_done (alpha_done),
        .ser_start  (ser_start),
        .ser_done   (ser_done),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .err_stage  (err_stage)
    );

    // Each stage answers with a one-cycle done pulse a few cycles after its start pulse.
    initial begin
        int cnt [0:3];
        logic [3:0] st;
        logic [3:0] dn;
        cnt = '{0, 0, 0, 0};
        forever begin
            @(negedge clk);
            st = {ser_start, alpha_start, len_start, sort_start};
            dn = 4'b0;
            for (int i = 0; i < 4; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) dn[i] = 1'b1;
                end
                if (st[i] && auto_en[i]) cnt[i] = 2;
            end
            dn_r = dn;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (code_we) begin
                wr_cnt++;
                cap[code_idx]     = code_out;
                wr_seen[code_idx] = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_cap();
        wr_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cap[i]     = '0;
            wr_seen[i] = 1'b0;
        end
    endtask

    task automatic kick(input string tag);
        clear_cap();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_sort_start"}, sort_start, 1);
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n;
        n = 0;
        while (!(done || err) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_terminated"}, done || err, 1);
    endtask

    task automatic wait_sig(input string tag, input int which, input int budget);
        int n;
        logic s;
        n = 0;
        s = 1'b0;
        while (n < budget) begin
            s = (which == 2) ? alpha_start : (which == 1) ? len_start : code_we && (code_idx == 4'd5);
            if (s) break;
            @(negedge clk);
            n++;
        end
        chk({tag, "_event_seen"}, s, 1);
    endtask

    task automatic check_t1(input string tag);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_writes"}, wr_cnt, 10);
        for (int i = 0; i < 10; i++) chk($sformatf("%s_code%0d", tag, i), cap[i], exp_t1[i]);
    endtask

    task automatic set_lens_t1();
        for (int i = 0; i < 16; i++) lens[i] = (i < 9) ? MAXHIGHT'(i + 1) : MAXHIGHT'(9);
    endtask

    initial begin
        int n;
        int ss;
        set_lens_t1();
        clear_cap();

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_err_stage", err_stage, 0);
        chk("rst_sort_start", sort_start, 0);
        chk("rst_code_we", code_we, 0);
        chk("rst_len_idx", len_idx, 0);
        chk("rst_code_out", code_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // T1: increasing lengths ending with a pair of 9s.
        kick("t1");
        chk("t1_busy_run", busy, 1);
        wait_end("t1", 300);
        check_t1("t1");

        // T2: ten symbols of length 4 give codes 0..9.
        for (int i = 0; i < 16; i++) lens[i] = MAXHIGHT'(4);
        kick("t2");
        wait_end("t2", 300);
        chk("t2_done", done, 1);
        chk("t2_err", err, 0);
        chk("t2_writes", wr_cnt, 10);
        for (int i = 0; i < 10; i++) chk($sformatf("t2_code%0d", i), cap[i], i);

        // T3: {1,1,2,...} overflows the Kraft sum at index 2.
        lens[0] = 1; lens[1] = 1;
        for (int i = 2; i < 16; i++) lens[i] = (i < 10) ? MAXHIGHT'(i) : MAXHIGHT'(9);
        kick("t3");
        wait_end("t3", 300);
        chk("t3_err", err, 1);
        chk("t3_done", done, 0);
        chk("t3_err_code", err_code, 4);
        chk("t3_err_stage", err_stage, 3);
        chk("t3_writes", wr_cnt, 2);
        chk("t3_no_write_idx2", wr_seen[2], 0);
        chk("t3_busy", busy, 0);

        // T4: length finder never answers.
        set_lens_t1();
        auto_en[1] = 1'b0;
        kick("t4");
        chk("t4_err_cleared", err, 0);
        wait_sig("t4_len_start", 1, 50);
        n = 0;
        while (busy && n < TIMEOUT + 20) begin
            n++;
            @(negedge clk);
        end
        chk("t4_cycles_in_len", (n >= TIMEOUT) && (n <= TIMEOUT + 1), 1);
        chk("t4_err", err, 1);
        chk("t4_err_code", err_code, 1);
        chk("t4_err_stage", err_stage, 2);

        // T5: abort coincides with alpha_done.
        auto_en[1] = 1'b1;
        auto_en[2] = 1'b0;
        kick("t5");
        chk("t5_err_cleared", err, 0);
        chk("t5_err_code_cleared", err_code, 0);
        wait_sig("t5_alpha_start", 2, 100);
        repeat (2) @(negedge clk);
        force_alpha = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        force_alpha = 1'b0;
        abort = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_err", err, 0);
        ss = 0;
        repeat (10) begin
            if (ser_start) ss++;
            @(negedge clk);
        end
        chk("t5_no_ser_start", ss, 0);
        auto_en[2] = 1'b1;

        // T6: asynchronous reset in the middle of codeword assignment, then a clean run.
        kick("t6a");
        wait_sig("t6_idx5", 0, 100);
        #1 rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_code_we", code_we, 0);
        chk("t6_len_idx", len_idx, 0);
        chk("t6_code_out", code_out, 0);
        chk("t6_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        kick("t6b");
        wait_end("t6b", 300);
        check_t1("t6b");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
